apple_spawner: RTL and testbench

- Produces the apple position consumed by the apple renderer: `x_start`/`y_start` in pixels, cell-aligned to the `SIZE` grid.
- Picks a pseudo-random grid cell from a free-running LFSR.
- Rejects cells outside the playfield, and cells the snake occupies (queried over a req/ack handshake with the snake body logic).
- Commits a new position at reset and after every `apple_eaten` pulse.

---
 rtl/apple_spawner_pkg.sv | 28 ++
 rtl/apple_spawner_lfsr16.sv | 30 +++
 rtl/apple_spawner.sv | 164 ++++++++++++++++
 tb/tb_apple_spawner.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apple_spawner_pkg.sv
// Shared game constants, LFSR definition and the apple spawner state type.
package apple_spawner_pkg;

    // Playfield geometry shared by the snake body logic and the renderers.
    localparam int BIT       = 10;  // pixel coordinate width
    localparam int SIZE      = 10;  // cell size in px
    localparam int GRID_COLS = 64;
    localparam int GRID_ROWS = 48;
    localparam int CELL_BIT  = 6;   // cell index width

    localparam int MAX_TRIES = 255;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        SP_IDLE,
        SP_DRAW,
        SP_WAIT,
        SP_COMMIT
    } spawn_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/apple_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR, reusable by any random game event.
module apple_spawner_lfsr16 #(
    parameter logic [15:0] SEED = apple_spawner_pkg::LFSR_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr_o
);
    import apple_spawner_pkg::*;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value of the shift register.
    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    // Register advances every cycle; reset reloads the seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/apple_spawner.sv
// Apple spawner: draws random grid cells, rejects out-of-field or snake
// occupied ones, and commits the pixel position of the next apple.
module apple_spawner #(
    parameter int          BIT       = apple_spawner_pkg::BIT,
    parameter int          SIZE      = apple_spawner_pkg::SIZE,
    parameter int          GRID_COLS = apple_spawner_pkg::GRID_COLS,
    parameter int          GRID_ROWS = apple_spawner_pkg::GRID_ROWS,
    parameter int          CELL_BIT  = apple_spawner_pkg::CELL_BIT,
    parameter logic [15:0] SEED      = apple_spawner_pkg::LFSR_SEED,
    parameter int          MAX_TRIES = apple_spawner_pkg::MAX_TRIES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                apple_eaten,
    output logic                occ_req,
    output logic [CELL_BIT-1:0] occ_col,
    output logic [CELL_BIT-1:0] occ_row,
    input  logic                occ_ack,
    input  logic                occ_hit,
    output logic [BIT-1:0]      x_start,
    output logic [BIT-1:0]      y_start,
    output logic                apple_valid,
    output logic                spawn_stuck
);
    import apple_spawner_pkg::*;

    localparam int                 TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]   TRY_MAX = TRY_W'(MAX_TRIES);
    localparam logic [BIT-1:0]     SIZE_PX = BIT'(SIZE);

    // The largest pixel coordinate must be representable, and cell indices
    // must cover the grid using disjoint LFSR bit fields.
    if (((GRID_COLS * SIZE) - 1) >= (2 ** BIT) ||
        ((GRID_ROWS * SIZE) - 1) >= (2 ** BIT)) begin : g_bad_px_width
        $error("apple_spawner: playfield pixel extent does not fit in BIT bits");
    end
    if ((2 ** CELL_BIT) < GRID_COLS || (2 ** CELL_BIT) < GRID_ROWS ||
        (2 * CELL_BIT) > 16) begin : g_bad_cell_width
        $error("apple_spawner: CELL_BIT cannot index the grid from the LFSR");
    end

    logic [15:0]         lfsr;
    logic [CELL_BIT-1:0] cand_col;
    logic [CELL_BIT-1:0] cand_row;
    logic                cand_ok;
    logic                unused_lfsr_hi;

    spawn_state_e        state_q, state_d;
    logic [TRY_W-1:0]    try_q, try_d;
    logic                stuck_q, stuck_d;
    logic                req_q, req_d;
    logic [CELL_BIT-1:0] col_q, col_d;
    logic [CELL_BIT-1:0] row_q, row_d;
    logic [BIT-1:0]      x_q, x_d;
    logic [BIT-1:0]      y_q, y_d;
    logic                valid_q, valid_d;

    apple_spawner_lfsr16 #(
        .SEED   (SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (lfsr)
    );

    assign cand_col       = lfsr[CELL_BIT-1:0];
    assign cand_row       = lfsr[2*CELL_BIT-1:CELL_BIT];
    assign cand_ok        = (int'(cand_col) < GRID_COLS) && (int'(cand_row) < GRID_ROWS);
    assign unused_lfsr_hi = ^lfsr[15:2*CELL_BIT];

    function automatic logic [TRY_W-1:0] try_inc(input logic [TRY_W-1:0] t);
        return (t == TRY_MAX) ? t : t + 1'b1;
    endfunction

    // Next-state and output logic of the spawn sequence.
    always_comb begin
        state_d = state_q;
        try_d   = try_q;
        stuck_d = stuck_q;
        req_d   = req_q;
        col_d   = col_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        case (state_q)
            SP_IDLE: begin
                if (apple_eaten) begin
                    valid_d = 1'b0;
                    state_d = SP_DRAW;
                end
            end
            SP_DRAW: begin
                if (cand_ok) begin
                    col_d   = cand_col;
                    row_d   = cand_row;
                    req_d   = 1'b1;
                    state_d = SP_WAIT;
                end else begin
                    try_d = try_inc(try_q);
                    if (try_d == TRY_MAX) stuck_d = 1'b1;
                end
            end
            SP_WAIT: begin
                // Query stays posted with a stable cell until it is answered.
                if (occ_ack) begin
                    req_d = 1'b0;
                    if (occ_hit) begin
                        try_d = try_inc(try_q);
                        if (try_d == TRY_MAX) stuck_d = 1'b1;
                        state_d = SP_DRAW;
                    end else begin
                        state_d = SP_COMMIT;
                    end
                end
            end
            SP_COMMIT: begin
                x_d     = BIT'(col_q) * SIZE_PX;
                y_d     = BIT'(row_q) * SIZE_PX;
                valid_d = 1'b1;
                try_d   = '0;
                stuck_d = 1'b0;
                state_d = SP_IDLE;
            end
            default: begin
                state_d = SP_DRAW;
            end
        endcase
    end

    // State and output registers; reset restarts a fresh spawn.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SP_DRAW;
            try_q   <= '0;
            stuck_q <= 1'b0;
            req_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            try_q   <= try_d;
            stuck_q <= stuck_d;
            req_q   <= req_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign occ_req     = req_q;
    assign occ_col     = col_q;
    assign occ_row     = row_q;
    assign x_start     = x_q;
    assign y_start     = y_q;
    assign apple_valid = valid_q;
    assign spawn_stuck = stuck_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Self-checking bench for apple_spawner: table of spawn scenarios, randomized
// spawns, and reset corner cases against a cycle-level spawn predictor.
module tb_apple_spawner;

    localparam int          BIT       = 10;
    localparam int          SIZE      = 10;
    localparam int          GRID_COLS = 64;
    localparam int          GRID_ROWS = 48;
    localparam int          CELL_BIT  = 6;
    localparam int          MAX_TRIES = 255;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          MAXC      = 8192;

    logic                clk;
    logic                reset;
    logic                apple_eaten;
    logic                occ_req;
    logic [CELL_BIT-1:0] occ_col;
    logic [CELL_BIT-1:0] occ_row;
    logic                occ_ack;
    logic                occ_hit;
    logic [BIT-1:0]      x_start;
    logic [BIT-1:0]      y_start;
    logic                apple_valid;
    logic                spawn_stuck;

    apple_spawner #(
        .BIT(BIT), .SIZE(SIZE), .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS),
        .CELL_BIT(CELL_BIT), .SEED(SEED), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .apple_eaten (apple_eaten),
        .occ_req     (occ_req),
        .occ_col     (occ_col),
        .occ_row     (occ_row),
        .occ_ack     (occ_ack),
        .occ_hit     (occ_hit),
        .x_start     (x_start),
        .y_start     (y_start),
        .apple_valid (apple_valid),
        .spawn_stuck (spawn_stuck)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [15:0] lfsr_tab [MAXC];
    int          ack_delay = 1;
    int          hit_n = 0;
    int          qidx = 0;
    int          req_age = 0;
    bit          ack_noise = 0;
    int          px = 0;
    int          py = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: 0 is the first cycle after the last reset edge.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Snake-body stand-in: answers each query ack_delay cycles after it is
    // seen, reporting a hit for the first hit_n queries of the spawn.
    initial begin
        occ_ack = 1'b0;
        occ_hit = 1'b0;
        forever begin
            @(negedge clk);
            if (occ_req === 1'b1) begin
                req_age++;
                if (req_age >= ack_delay + 1) begin
                    occ_ack = 1'b1;
                    occ_hit = (qidx < hit_n);
                    qidx++;
                end else begin
                    occ_ack = 1'b0;
                    occ_hit = 1'($urandom_range(0, 1));
                end
            end else begin
                req_age = 0;
                occ_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                occ_hit = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Candidate stream from the polynomial: value present in each cycle.
    task automatic build_lfsr_table();
        int          taps [4] = '{16, 14, 13, 11};
        logic [15:0] mask = 16'h0;
        logic [15:0] v;
        foreach (taps[i]) mask = mask | (16'h1 << (taps[i] - 1));
        lfsr_tab[0] = SEED;
        for (int i = 1; i < MAXC; i++) begin
            v = lfsr_tab[i-1];
            lfsr_tab[i] = (v >> 1) ^ (v[0] ? mask : 16'h0);
        end
    endtask

    // Walks the spawn rules from draw cycle s: one cycle per out-of-field
    // candidate, query answered d cycles after it appears, first h queries hit.
    function automatic void predict(input int s, input int h, input int d,
                                    output int col, output int row, output int vcyc,
                                    output int scyc, output int nq);
        int c   = s;
        int rej = 0;
        int q   = 0;
        int a;
        col = 0; row = 0; vcyc = -1; scyc = -1; nq = 0;
        while (c < MAXC) begin
            col = int'(lfsr_tab[c]) % (2 ** CELL_BIT);
            row = (int'(lfsr_tab[c]) / (2 ** CELL_BIT)) % (2 ** CELL_BIT);
            if (col >= GRID_COLS || row >= GRID_ROWS) begin
                rej++;
                if (rej == MAX_TRIES) scyc = c + 1;
                c++;
            end else begin
                a = c + 1 + d;
                q++;
                if (q <= h) begin
                    rej++;
                    if (rej == MAX_TRIES) scyc = a + 1;
                    c = a + 1;
                end else begin
                    nq   = q;
                    vcyc = a + 2;
                    return;
                end
            end
        end
    endfunction

    // Observes one spawn from its first draw cycle s until apple_valid.
    task automatic run_spawn(input int s, input int h, input int d, input bit noise,
                             input string nm, output int nreq, output int fcol,
                             output int frow, output bit stuck_seen);
        int pcol, prow, vcyc, scyc, pq;
        int qcol = -1, qrow = -1;
        bit prev_req = 1'b0, prev_ack = 1'b0, done = 1'b0;
        int unstable = 0, dropped = 0, moved = 0, stuck_err = 0;
        predict(s, h, d, pcol, prow, vcyc, scyc, pq);
        nreq = 0; fcol = -1; frow = -1; stuck_seen = 1'b0;
        while (!done && cyc < s + 4000) begin
            if (occ_req) begin
                if (!prev_req) begin
                    nreq++;
                    qcol = int'(occ_col);
                    qrow = int'(occ_row);
                    if (nreq == 1) begin fcol = qcol; frow = qrow; end
                end else if (int'(occ_col) != qcol || int'(occ_row) != qrow) begin
                    unstable++;
                end
            end else if (prev_req && !prev_ack) begin
                dropped++;
            end
            if (apple_valid) begin
                done = 1'b1;
            end else begin
                if (int'(x_start) != px || int'(y_start) != py) moved++;
                if (spawn_stuck) stuck_seen = 1'b1;
                if (spawn_stuck !== ((scyc >= 0) && (cyc >= scyc))) stuck_err++;
                prev_req    = occ_req;
                prev_ack    = occ_ack;
                apple_eaten = noise && occ_req && (cyc % 5 == 0);
                tick();
            end
        end
        apple_eaten = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: apple_valid still 0 at cycle %0d, expected at %0d", nm, cyc, vcyc);
            return;
        end
        check({nm, " commit cycle"}, cyc, vcyc);
        check({nm, " query count"}, nreq, pq);
        check({nm, " x_start"}, x_start, pcol * SIZE);
        check({nm, " y_start"}, y_start, prow * SIZE);
        check({nm, " x vs last query"}, x_start, qcol * SIZE);
        check({nm, " y vs last query"}, y_start, qrow * SIZE);
        check({nm, " stuck cleared"}, spawn_stuck, 0);
        check({nm, " query hold violations"}, unstable, 0);
        check({nm, " req drops without ack"}, dropped, 0);
        check({nm, " position moves before commit"}, moved, 0);
        check({nm, " stuck timing errors"}, stuck_err, 0);
        px = int'(x_start);
        py = int'(y_start);
    endtask

    // Holds in IDLE for n cycles; nothing may change there.
    task automatic idle_hold(input int n, input string nm);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (apple_valid !== 1'b1 || occ_req !== 1'b0 || spawn_stuck !== 1'b0 ||
                int'(x_start) != px || int'(y_start) != py) errs++;
            tick();
        end
        check({nm, " idle disturbances"}, errs, 0);
    endtask

    task automatic pulse_eaten(input string nm, output int s);
        apple_eaten = 1'b1;
        tick();
        apple_eaten = 1'b0;
        s = cyc;
        check({nm, " apple_valid drops"}, apple_valid, 0);
    endtask

    typedef struct {
        int hits;
        int delay;
        bit noise;
        int exp_reqs;
        bit exp_stuck;
    } vec_t;

    initial begin
        vec_t  vecs [6];
        int    s, nreq, fcol, frow, first_col, first_row, waited;
        bit    stk;
        string nm;

        vecs[0] = '{0,   1,  1'b0, 1,   1'b0};
        vecs[1] = '{3,   1,  1'b0, 4,   1'b0};
        vecs[2] = '{1,   0,  1'b0, 2,   1'b0};
        vecs[3] = '{2,   3,  1'b0, 3,   1'b0};
        vecs[4] = '{0,   50, 1'b1, 1,   1'b0};
        vecs[5] = '{300, 1,  1'b0, 301, 1'b1};

        build_lfsr_table();
        reset       = 1'b1;
        apple_eaten = 1'b0;
        hit_n = 0; ack_delay = 1; qidx = 0;
        repeat (3) tick();
        check("reset occ_req", occ_req, 0);
        check("reset apple_valid", apple_valid, 0);
        check("reset x_start", x_start, 0);
        check("reset y_start", y_start, 0);
        check("reset spawn_stuck", spawn_stuck, 0);

        // First spawn straight out of reset.
        reset = 1'b0;
        run_spawn(0, 0, 1, 1'b0, "post-reset spawn", nreq, first_col, first_row, stk);
        check("x_start within field", (x_start <= 10'd630), 1);
        check("y_start within field", (y_start <= 10'd470), 1);
        idle_hold(5, "post-reset");

        foreach (vecs[i]) begin
            nm = $sformatf("vec%0d", i);
            hit_n = vecs[i].hits; ack_delay = vecs[i].delay; qidx = 0;
            pulse_eaten(nm, s);
            run_spawn(s, vecs[i].hits, vecs[i].delay, vecs[i].noise, nm, nreq, fcol, frow, stk);
            check({nm, " table query count"}, nreq, vecs[i].exp_reqs);
            check({nm, " table stuck seen"}, stk, vecs[i].exp_stuck);
            idle_hold(20, nm);
        end

        ack_noise = 1'b1;
        for (int i = 0; i < 25; i++) begin
            int h, d;
            bit nz;
            nm = $sformatf("rand%0d", i);
            h  = $urandom_range(0, 3);
            d  = $urandom_range(0, 4);
            nz = 1'($urandom_range(0, 1));
            hit_n = h; ack_delay = d; qidx = 0;
            idle_hold($urandom_range(1, 6), nm);
            pulse_eaten(nm, s);
            run_spawn(s, h, d, nz, nm, nreq, fcol, frow, stk);
        end
        ack_noise = 1'b0;
        idle_hold(3, "pre-abort");

        // Reset while a query is outstanding, then replay the first spawn.
        hit_n = 0; ack_delay = 1000; qidx = 0;
        pulse_eaten("abort", s);
        waited = 0;
        while (occ_req !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        check("abort reached query", occ_req, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort occ_req", occ_req, 0);
        check("abort apple_valid", apple_valid, 0);
        check("abort x_start", x_start, 0);
        check("abort y_start", y_start, 0);
        reset = 1'b0;
        ack_delay = 1; qidx = 0; hit_n = 0;
        px = 0; py = 0;
        run_spawn(0, 0, 1, 1'b0, "replay spawn", nreq, fcol, frow, stk);
        check("replay first col", fcol, first_col);
        check("replay first row", frow, first_row);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
